// File: rtl/ipc_message_writer.sv
`default_nettype none
// ============================================================================
// Module  : ipc_message_writer
// Brief   : Serialises one formatted WIDTH-bit IPC message into a byte frame
//           (SOF, payload LSB-first, 8-bit checksum) on a valid/ack link.
// Revision: 1.0 - initial release
// ============================================================================
module ipc_message_writer #(
    parameter int         WIDTH = 64,
    parameter logic [7:0] SOF   = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ack,
    output logic             busy,
    output logic [15:0]      frames_sent
);

    localparam int NBYTES = WIDTH / 8;
    // A single-byte message still needs a 1-bit index to stay a legal vector.
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_csum;
    logic [15:0]      r_frames;
    logic             r_ready;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;

    logic [WIDTH-1:0] w_shift_next;
    logic [7:0]       w_csum_next;

    assign w_shift_next = r_shift >> 8;
    assign w_csum_next  = r_csum + r_shift[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_csum     <= 8'h00;
            r_frames   <= 16'h0000;
            r_ready    <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift    <= data_in;
                        r_idx      <= '0;
                        r_csum     <= 8'h00;
                        r_state    <= HEADER;
                        r_ready    <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= SOF;
                    end
                end
                HEADER: begin
                    if (tx_ack) begin
                        r_state   <= PAYLOAD;
                        r_tx_data <= r_shift[7:0];
                    end
                end
                PAYLOAD: begin
                    // Output byte is staged one ahead so tx_data stays registered.
                    if (tx_ack) begin
                        r_csum  <= w_csum_next;
                        r_shift <= w_shift_next;
                        if (r_idx == c_last_idx) begin
                            r_idx     <= '0;
                            r_state   <= CHECKSUM;
                            r_tx_data <= w_csum_next;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            r_tx_data <= w_shift_next[7:0];
                        end
                    end
                end
                CHECKSUM: begin
                    if (tx_ack) begin
                        r_frames   <= r_frames + 16'd1;
                        r_state    <= IDLE;
                        r_ready    <= 1'b1;
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ready    <= 1'b1;
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= 8'h00;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign busy        = ~r_ready;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign frames_sent = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_ipc_message_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ipc_message_writer
// Brief   : Directed self-checking bench with a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ipc_message_writer;

    localparam int NB = 8;
    localparam logic [7:0] SOF_V = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [63:0] data_in = 64'h0;
    logic        tx_ack = 1'b0;
    logic        ready, tx_valid, busy;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;

    int total = 0;
    int bad = 0;
    int low_cycles = 0;
    logic [7:0] got[$];
    logic preload_ev = 1'b0;

    ipc_message_writer #(.WIDTH(64), .SOF(SOF_V)) dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
        .ready(ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
        .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    // Reference model: a whole frame as a byte list plus a position cursor.
    typedef logic [7:0] frame_t [0:NB+1];

    function automatic frame_t build_frame(input logic [63:0] d);
        frame_t f;
        logic [7:0] s;
        s = 8'h00;
        f[0] = SOF_V;
        for (int i = 0; i < NB; i++) begin
            f[i+1] = d[8*i +: 8];
            s = s + d[8*i +: 8];
        end
        f[NB+1] = s;
        return f;
    endfunction

    frame_t      mf;
    logic        m_active;
    int          m_pos;
    logic [15:0] m_count;

    always @(posedge clk or posedge reset or posedge preload_ev) begin
        if (reset) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_count  <= 16'h0;
        end else if (preload_ev) begin
            m_count <= 16'hFFFF;
        end else if (!m_active) begin
            if (load) begin
                mf       <= build_frame(data_in);
                m_pos    <= 0;
                m_active <= 1'b1;
            end
        end else if (tx_ack) begin
            if (m_pos == NB + 1) begin
                m_active <= 1'b0;
                m_count  <= m_count + 16'd1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("tx_valid", {79'd0, tx_valid}, {79'd0, m_active});
        check("ready", {79'd0, ready}, {79'd0, ~m_active});
        check("busy", {79'd0, busy}, {79'd0, m_active});
        check("frames_sent", {64'd0, frames_sent}, {64'd0, m_count});
        if (m_active) check("tx_data", {72'd0, tx_data}, {72'd0, mf[m_pos]});
        if (tx_valid && tx_ack) got.push_back(tx_data);
        if (!ready) low_cycles++;
    end

    function automatic logic [79:0] packed_got();
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            r = {r[71:0], (i < got.size()) ? got[i] : 8'h00};
        return r;
    endfunction

    task automatic check_frame(input string nm, input logic [79:0] exp);
        check({nm, "_len"}, 80'(got.size()), 80'd10);
        check(nm, packed_got(), exp);
        got.delete();
    endtask

    // Load one message, then walk the ten frame positions, optionally
    // stalling SOF, payload byte 3 and the checksum for three cycles each.
    task automatic run_frame(input logic [63:0] d, input bit stall, input int junk_at);
        load = 1'b1;
        data_in = d;
        @(posedge clk); #1;
        load = 1'b0;
        data_in = ~d;
        for (int p = 0; p < 10; p++) begin
            if (stall && (p == 0 || p == 4 || p == 9)) begin
                tx_ack = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
            if (p == junk_at) begin
                load = 1'b1;
                data_in = 64'hDEAD_BEEF_CAFE_F00D;
            end
            tx_ack = 1'b1;
            @(posedge clk); #1;
            load = 1'b0;
        end
        tx_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {79'd0, ready}, 80'd1);
        check("rst_tx_valid", {79'd0, tx_valid}, 80'd0);
        check("rst_tx_data", {72'd0, tx_data}, 80'd0);
        check("rst_frames", {64'd0, frames_sent}, 80'd0);
        got.delete();

        low_cycles = 0;
        run_frame(64'h0000_0000_0000_0001, 1'b0, -1);
        check_frame("frame_one", 80'hA5_01_00_00_00_00_00_00_00_01);
        check("ready_low_cycles", 80'(low_cycles), 80'd10);
        check("frames_after_one", {64'd0, frames_sent}, 80'd1);

        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1);
        check_frame("frame_ff", 80'hA5_FF_FF_FF_FF_FF_FF_FF_FF_F8);
        check("b2b_ready", {79'd0, ready}, 80'd1);
        run_frame(64'h0807_0605_0403_0201, 1'b0, -1);
        check_frame("frame_seq", 80'hA5_01_02_03_04_05_06_07_08_24);
        check("frames_after_b2b", {64'd0, frames_sent}, 80'd3);

        low_cycles = 0;
        run_frame(64'h0807_0605_0403_0201, 1'b1, -1);
        check_frame("frame_stall", 80'hA5_01_02_03_04_05_06_07_08_24);
        check("stall_cycles", 80'(low_cycles), 80'd19);

        run_frame(64'h1122_3344_5566_7788, 1'b0, 5);
        check_frame("frame_junk_load", 80'hA5_88_77_66_55_44_33_22_11_64);
        check("frames_after_junk", {64'd0, frames_sent}, 80'd5);

        load = 1'b1;
        data_in = 64'h0807_0605_0403_0201;
        @(posedge clk); #1;
        load = 1'b0;
        tx_ack = 1'b1;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_tx_valid", {79'd0, tx_valid}, 80'd0);
        check("arst_ready", {79'd0, ready}, 80'd1);
        check("arst_busy", {79'd0, busy}, 80'd0);
        check("arst_frames", {64'd0, frames_sent}, 80'd0);
        check("arst_tx_data", {72'd0, tx_data}, 80'd0);
        tx_ack = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        got.delete();
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1);
        check_frame("frame_after_reset", 80'hA5_FF_FF_FF_FF_FF_FF_FF_FF_F8);
        check("frames_after_reset", {64'd0, frames_sent}, 80'd1);

        tx_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ack_valid", {79'd0, tx_valid}, 80'd0);
        check("idle_ack_frames", {64'd0, frames_sent}, 80'd1);
        tx_ack = 1'b0;
        check("idle_ack_nobytes", 80'(got.size()), 80'd0);

        @(posedge clk); #1;
        force dut.r_frames = 16'hFFFF;
        release dut.r_frames;
        preload_ev = 1'b1;
        @(posedge clk); #1;
        preload_ev = 1'b0;
        check("preload_frames", {64'd0, frames_sent}, 80'hFFFF);
        run_frame(64'h0000_0000_0000_0001, 1'b0, -1);
        check_frame("frame_wrap", 80'hA5_01_00_00_00_00_00_00_00_01);
        check("frames_wrap", {64'd0, frames_sent}, 80'd0);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
